w_stage_grf: RTL

- Writeback stage plus general register file of the 5-stage MIPS core.
- Consumes the W-stage pipeline register outputs (instr, PC, ALUOut, DMOut, EXTOut, CMPOut).
- Decodes the write destination and source, and commits the write into a 32x32 register file.
- Serves the two D-stage read ports with write-through bypass, exposes W-stage write info to the hazard/forward unit, and keeps a retired-instruction counter.

---
 rtl/w_stage_grf.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/w_stage_grf.sv
// ---------------------------------------------------------------------------
// w_stage_grf -- writeback stage and general register file of the 5-stage
// MIPS core.
//
// The W-stage pipeline register outputs are decoded into a single register
// write (destination, data, enable).  That write is committed into a 32x32
// register file on the rising clock edge.  The same write is also forwarded
// combinationally to the two D-stage read ports, so an instruction in D sees
// a value that is being retired in the same cycle.  The write info (W_we,
// W_wa, W_wd) is exported for the hazard/forward unit.  A retired-instruction
// counter counts every non-nop instruction that passes through W.
//
// Register $0 is hardwired to zero.  A decoded write to $0 is suppressed, so
// W_we stays low and W_wa/W_wd read 0.
//
// Reset is asynchronous and active low.  While reset is low the register
// file and the counter are held at zero and nothing is written.
//
// Optional build macro:
//   GRF_TRACE_EN  When defined, every committed register write prints a
//                 course-judge style trace line "@pppppppp: $nn <= dddddddd".
//                 When undefined, no display code is compiled.
// ---------------------------------------------------------------------------
module w_stage_grf #(
   parameter int unsigned LINK_OFFSET = 8,
   parameter int unsigned RET_CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          W_instr,
   input  logic [31:0]          W_PC,
   input  logic [31:0]          W_ALUOut,
   input  logic [31:0]          W_DMOut,
   input  logic [31:0]          W_EXTOut,
   input  logic                 W_CMPOut,
   input  logic [4:0]           D_rs_addr,
   input  logic [4:0]           D_rt_addr,
   output logic [31:0]          D_rs_data,
   output logic [31:0]          D_rt_data,
   output logic                 W_we,
   output logic [4:0]           W_wa,
   output logic [31:0]          W_wd,
   output logic [RET_CNT_W-1:0] ret_cnt
);

   // ------------------------------------------------------------------------
   // Opcode and function-code constants for the instructions that write back.
   // ------------------------------------------------------------------------
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_SLT     = 6'h2a;
   localparam logic [5:0] FN_SLTU    = 6'h2b;

   // REGIMM rt field selecting bgezal
   localparam logic [4:0] RT_BGEZAL  = 5'h11;

   // Link register used by jal and bgezal
   localparam logic [4:0] REG_RA     = 5'd31;

   // Counter increment constant, sized to the counter width
   localparam logic [RET_CNT_W-1:0] CNT_ONE = 1;

   // ------------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------------
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] link_val;
   logic        instr_is_nop;

   assign op           = W_instr[31:26];
   assign funct        = W_instr[5:0];
   assign rt           = W_instr[20:16];
   assign rd           = W_instr[15:11];
   assign instr_is_nop = (W_instr == 32'h0000_0000);

   // Return address for link instructions; wraps modulo 2^32 naturally.
   assign link_val     = W_PC + 32'(LINK_OFFSET);

   // ------------------------------------------------------------------------
   // Writeback decode results (before $0 suppression)
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_EXT  = 2'd1,
      SRC_DM   = 2'd2,
      SRC_LINK = 2'd3
   } wb_src_e;

   logic        dec_write;
   logic [4:0]  dec_dest;
   wb_src_e     dec_src;
   logic [31:0] dec_data;

   // Decode which register (if any) the W-stage instruction writes and where
   // its data comes from.
   always_comb begin
      dec_write = 1'b0;
      dec_dest  = 5'd0;
      dec_src   = SRC_ALU;
      unique case (op)
         OP_SPECIAL: begin
            unique case (funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU, FN_SLL: begin
                  dec_write = 1'b1;
                  dec_dest  = rd;
                  dec_src   = SRC_ALU;
               end
               FN_JALR: begin
                  dec_write = 1'b1;
                  dec_dest  = rd;
                  dec_src   = SRC_LINK;
               end
               default: begin
                  dec_write = 1'b0;
               end
            endcase
         end
         OP_ADDIU, OP_ANDI, OP_ORI: begin
            dec_write = 1'b1;
            dec_dest  = rt;
            dec_src   = SRC_ALU;
         end
         OP_LUI: begin
            dec_write = 1'b1;
            dec_dest  = rt;
            dec_src   = SRC_EXT;
         end
         OP_LW: begin
            dec_write = 1'b1;
            dec_dest  = rt;
            dec_src   = SRC_DM;
         end
         OP_JAL: begin
            dec_write = 1'b1;
            dec_dest  = REG_RA;
            dec_src   = SRC_LINK;
         end
         OP_REGIMM: begin
            // bgezal links only when the branch condition held
            if (rt == RT_BGEZAL && W_CMPOut) begin
               dec_write = 1'b1;
               dec_dest  = REG_RA;
               dec_src   = SRC_LINK;
            end
         end
         default: begin
            dec_write = 1'b0;
         end
      endcase
   end

   // Select the writeback data source.
   always_comb begin
      dec_data = W_ALUOut;
      unique case (dec_src)
         SRC_ALU:  dec_data = W_ALUOut;
         SRC_EXT:  dec_data = W_EXTOut;
         SRC_DM:   dec_data = W_DMOut;
         SRC_LINK: dec_data = link_val;
         default:  dec_data = W_ALUOut;
      endcase
   end

   // ------------------------------------------------------------------------
   // Exported write info.  Writes to $0 are dropped here so that neither the
   // array nor the bypass nor the forward unit ever sees them; address and
   // data are zeroed whenever no write happens to keep the outputs quiet.
   // ------------------------------------------------------------------------
   assign W_we = dec_write && (dec_dest != 5'd0);
   assign W_wa = W_we ? dec_dest : 5'd0;
   assign W_wd = W_we ? dec_data : 32'h0000_0000;

   // ------------------------------------------------------------------------
   // Register file storage
   // ------------------------------------------------------------------------
   logic [31:0] regs [32];

   // Commit the writeback into the array; reset clears every entry at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0000_0000;
         end
      end else if (W_we) begin
         regs[W_wa] <= W_wd;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports with same-cycle write-through bypass.  $0 is forced to zero
   // regardless of the array contents.
   // ------------------------------------------------------------------------

   // Read port 1 (rs)
   always_comb begin
      D_rs_data = 32'h0000_0000;
      if (D_rs_addr == 5'd0) begin
         D_rs_data = 32'h0000_0000;
      end else if (W_we && (D_rs_addr == W_wa)) begin
         D_rs_data = W_wd;
      end else begin
         D_rs_data = regs[D_rs_addr];
      end
   end

   // Read port 2 (rt)
   always_comb begin
      D_rt_data = 32'h0000_0000;
      if (D_rt_addr == 5'd0) begin
         D_rt_data = 32'h0000_0000;
      end else if (W_we && (D_rt_addr == W_wa)) begin
         D_rt_data = W_wd;
      end else begin
         D_rt_data = regs[D_rt_addr];
      end
   end

   // ------------------------------------------------------------------------
   // Retired-instruction counter.  Every non-nop instruction counts, whether
   // or not it writes a register (branches and stores retire too).  The
   // counter wraps from all-ones to zero.
   // ------------------------------------------------------------------------

   // Count retired non-nop instructions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_cnt <= '0;
      end else if (!instr_is_nop) begin
         ret_cnt <= ret_cnt + CNT_ONE;
      end
   end

`ifdef GRF_TRACE_EN
   // Print one trace line per committed register write.
   always @(posedge clk) begin
      if (reset && W_we) begin
         $display("@%h: $%2d <= %h", W_PC, W_wa, W_wd);
      end
   end
`endif

endmodule
